// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared definitions for the interrupt controller.
//   INT_BASE            default base of the 16-byte register window
//   int_off_e           word offsets within the window (ACK/PEND/CFG/STAT)
//   IRQ_TC0/TC1/EXT     source bit indices
//   N_IRQ               number of sources (one per CP0 IP bit)
package int_ctrl_pkg;

    localparam logic [31:0] INT_BASE = 32'h0000_7f20;

    typedef enum logic [1:0] {
        INT_ACK  = 2'd0,
        INT_PEND = 2'd1,
        INT_CFG  = 2'd2,
        INT_STAT = 2'd3
    } int_off_e;

    localparam int unsigned IRQ_TC0 = 0;
    localparam int unsigned IRQ_TC1 = 1;
    localparam int unsigned IRQ_EXT = 2;

    localparam int unsigned N_IRQ = 6;

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index priority encoder.
//   req   in  W   request vector
//   idx   out 3   index of lowest set bit of req, 3'b111 when none set
//   valid out 1   |req
module int_prio_enc #(
    parameter int unsigned W = 6
) (
    input  logic [W-1:0] req,
    output logic [2:0]   idx,
    output logic         valid
);

    always_comb begin
        idx   = '1;
        valid = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (req[i] && !valid) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller feeding CP0 Cause.IP.
//   clk, reset     system clock, synchronous active-high reset
//   irq_src        raw source levels (bit0 TC0, bit1 TC1, bit2 external pin)
//   m_int_addr     bus byte address; window is BASE_ADDR..BASE_ADDR+15
//   m_int_byteen   write byte enables, non-zero means a write
//   m_int_wdata    write data
//   m_int_rdata    combinational read data (0 outside the window)
//   hw_int         registered pending & mask, to CP0
//   int_any        registered |hw_int
// Registers: +0 ACK (write clears external pending), +4 PENDING (W1C for
// edge sources), +8 CONFIG (mask[5:0], edge_mode[13:8]), +C STATUS.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = INT_BASE,
    parameter int unsigned N_SRC     = N_IRQ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [31:0]      m_int_addr,
    input  logic [3:0]       m_int_byteen,
    input  logic [31:0]      m_int_wdata,
    output logic [31:0]      m_int_rdata,
    output logic [N_SRC-1:0] hw_int,
    output logic             int_any
);

    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] edge_mode;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending_next;
    logic [31:0]      addr_w;
    logic             sel;
    logic             wr;
    int_off_e         off;
    logic [2:0]       stat_idx;
    logic             stat_valid;
    logic             unused_wdata;

    assign addr_w = m_int_addr & ~32'h3;
    assign sel    = (addr_w >= BASE_ADDR) && (addr_w <= BASE_ADDR + 32'd12);
    assign wr     = sel && (m_int_byteen != '0);
    assign off    = int_off_e'(m_int_addr[3:2]);

    assign unused_wdata = ^{m_int_wdata[31:14], m_int_wdata[7:N_SRC]};

    always_comb begin
        clr = '0;
        if (wr && off == INT_ACK)
            clr[IRQ_EXT] = 1'b1;
        if (wr && off == INT_PEND && m_int_byteen[0])
            clr = clr | m_int_wdata[N_SRC-1:0];
    end

    // src_q resets to 0, so the reset posedge itself never records an edge;
    // a source still high at the first post-reset posedge counts as a rising
    // edge there, and hw_int follows one cycle later.
    assign rise = irq_src & ~src_q;

    // Edge sources: set beats clear in the same cycle. Level sources simply
    // follow the input, so W1C/ACK have no lasting effect on them.
    assign pending_next = (edge_mode & (rise | (pending & ~clr)))
                        | (~edge_mode & irq_src);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            src_q     <= '0;
            mask      <= '1;
            edge_mode <= '1;
            hw_int    <= '0;
            int_any   <= 1'b0;
        end else begin
            src_q   <= irq_src;
            pending <= pending_next;
            hw_int  <= pending & mask;
            int_any <= |(pending & mask);
            if (wr && off == INT_CFG) begin
                if (m_int_byteen[0])
                    mask <= m_int_wdata[N_SRC-1:0];
                if (m_int_byteen[1])
                    edge_mode <= m_int_wdata[8 +: N_SRC];
            end
        end
    end

    int_prio_enc #(
        .W (N_SRC)
    ) u_prio (
        .req   (hw_int),
        .idx   (stat_idx),
        .valid (stat_valid)
    );

    always_comb begin
        m_int_rdata = '0;
        if (sel) begin
            unique case (off)
                INT_ACK:  m_int_rdata = '0;
                INT_PEND: m_int_rdata[N_SRC-1:0] = pending;
                INT_CFG: begin
                    m_int_rdata[N_SRC-1:0] = mask;
                    m_int_rdata[8 +: N_SRC] = edge_mode;
                end
                INT_STAT: begin
                    m_int_rdata[31]  = stat_valid;
                    m_int_rdata[2:0] = stat_idx;
                end
                default: m_int_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: scoreboard bench for int_ctrl. Each task pushes expected
// values as it drives stimulus, collects observations, and compares them
// against the popped expectations.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_src;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic [31:0] m_int_wdata;
    logic [31:0] m_int_rdata;
    logic [5:0]  hw_int;
    logic        int_any;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    localparam logic [31:0] A_ACK  = 32'h0000_7f20;
    localparam logic [31:0] A_PEND = 32'h0000_7f24;
    localparam logic [31:0] A_CFG  = 32'h0000_7f28;
    localparam logic [31:0] A_STAT = 32'h0000_7f2c;

    always #5 clk = ~clk;

    int_ctrl #(
        .BASE_ADDR (32'h0000_7f20),
        .N_SRC     (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_src      (irq_src),
        .m_int_addr   (m_int_addr),
        .m_int_byteen (m_int_byteen),
        .m_int_wdata  (m_int_wdata),
        .m_int_rdata  (m_int_rdata),
        .hw_int       (hw_int),
        .int_any      (int_any)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic step(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_val(input string nm, input logic [31:0] v);
        name_q.push_back(nm);
        exp_q.push_back(v);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        m_int_addr   = a;
        m_int_byteen = '0;
        #1;
        d = m_int_rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        m_int_addr   = a;
        m_int_byteen = be;
        m_int_wdata  = d;
        step();
        m_int_byteen = '0;
        m_int_wdata  = '0;
    endtask

    task automatic test_reset();
        logic [31:0] got[$];
        logic [31:0] d;
        reset        = 1'b1;
        irq_src      = '0;
        m_int_addr   = '0;
        m_int_byteen = '0;
        m_int_wdata  = '0;
        step(2);
        reset = 1'b0;
        expect_val("reset rd ack", 32'h0);           rd(A_ACK, d);  got.push_back(d);
        expect_val("reset rd pend", 32'h0);          rd(A_PEND, d); got.push_back(d);
        expect_val("reset rd cfg", 32'h0000_3f3f);   rd(A_CFG, d);  got.push_back(d);
        expect_val("reset rd stat", 32'h0000_0007);  rd(A_STAT, d); got.push_back(d);
        expect_val("reset hw_int", 32'h0);           got.push_back(32'(hw_int));
        expect_val("reset int_any", 32'h0);          got.push_back(32'(int_any));
        foreach (got[i]) begin
            logic [31:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_total++;
            if (got[i] !== e) $display("FAIL %s: got %h required %h", nm, got[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_ext_pulse();
        logic [31:0] got[$];
        logic [31:0] d;
        irq_src[2] = 1'b1;
        step();
        expect_val("ext hw_int not yet", 32'h0);  got.push_back(32'(hw_int));
        irq_src[2] = 1'b0;
        step();
        expect_val("ext hw_int set", 32'h4);      got.push_back(32'(hw_int));
        expect_val("ext int_any set", 32'h1);     got.push_back(32'(int_any));
        step(5);
        expect_val("ext hw_int held", 32'h4);     got.push_back(32'(hw_int));
        expect_val("ext pend read", 32'h4);       rd(A_PEND, d); got.push_back(d);
        expect_val("ext stat read", 32'h8000_0002); rd(A_STAT, d); got.push_back(d);
        wr(A_ACK, 4'b0001, 32'h0);
        expect_val("ack hw_int still", 32'h4);    got.push_back(32'(hw_int));
        expect_val("ack pend cleared", 32'h0);    rd(A_PEND, d); got.push_back(d);
        step();
        expect_val("ack hw_int clear", 32'h0);    got.push_back(32'(hw_int));
        expect_val("ack int_any clear", 32'h0);   got.push_back(32'(int_any));
        foreach (got[i]) begin
            logic [31:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_total++;
            if (got[i] !== e) $display("FAIL %s: got %h required %h", nm, got[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_w1c_status();
        logic [31:0] got[$];
        logic [31:0] d;
        irq_src[1:0] = 2'b11;
        step();
        irq_src[1:0] = 2'b00;
        step();
        expect_val("w1c stat both", 32'h8000_0000); rd(A_STAT, d); got.push_back(d);
        wr(A_PEND, 4'b0001, 32'h1);
        step();
        expect_val("w1c stat tc1", 32'h8000_0001);  rd(A_STAT, d); got.push_back(d);
        wr(A_PEND, 4'b0001, 32'h2);
        step();
        expect_val("w1c stat none", 32'h0000_0007); rd(A_STAT, d); got.push_back(d);
        expect_val("w1c pend none", 32'h0);         rd(A_PEND, d); got.push_back(d);
        foreach (got[i]) begin
            logic [31:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_total++;
            if (got[i] !== e) $display("FAIL %s: got %h required %h", nm, got[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        logic [31:0] d;
        // held-high edge source must not re-latch after being cleared
        irq_src[0] = 1'b1;
        step();
        wr(A_PEND, 4'b0001, 32'h1);
        step(3);
        expect_val("held no relatch pend", 32'h0);  rd(A_PEND, d); got.push_back(d);
        expect_val("held no relatch hw", 32'h0);    got.push_back(32'(hw_int));
        irq_src[0] = 1'b0;
        step();
        irq_src[0] = 1'b1;
        step();
        expect_val("rearm pend", 32'h1);            rd(A_PEND, d); got.push_back(d);
        step();
        expect_val("rearm hw", 32'h1);              got.push_back(32'(hw_int));
        // writes that must be ignored
        wr(A_PEND, 4'b0010, 32'h1);
        expect_val("w1c byte0 off ignored", 32'h1); rd(A_PEND, d); got.push_back(d);
        wr(32'h0000_7f30, 4'b1111, 32'h1);
        expect_val("oow write ignored", 32'h1);     rd(A_PEND, d); got.push_back(d);
        expect_val("oow read hi", 32'h0);           rd(32'h0000_7f30, d); got.push_back(d);
        expect_val("oow read lo", 32'h0);           rd(32'h0000_7f1c, d); got.push_back(d);
        wr(A_STAT, 4'b1111, 32'hffff_ffff);
        expect_val("stat write ignored", 32'h0000_3f3f); rd(A_CFG, d); got.push_back(d);
        irq_src[0] = 1'b0;
        wr(A_PEND, 4'b0001, 32'h1);
        step();
        expect_val("b2b cleanup pend", 32'h0);      rd(A_PEND, d); got.push_back(d);
        foreach (got[i]) begin
            logic [31:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_total++;
            if (got[i] !== e) $display("FAIL %s: got %h required %h", nm, got[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_config_level();
        logic [31:0] got[$];
        logic [31:0] d;
        wr(A_CFG, 4'b0011, 32'h0000_0302);
        expect_val("cfg readback", 32'h0000_0302);  rd(A_CFG, d); got.push_back(d);
        irq_src = 6'h3f;
        step();
        expect_val("all high pend", 32'h3f);        rd(A_PEND, d); got.push_back(d);
        step();
        expect_val("mask tc1 hw", 32'h02);          got.push_back(32'(hw_int));
        irq_src = 6'h1f;
        step();
        expect_val("level drop pend", 32'h1f);      rd(A_PEND, d); got.push_back(d);
        wr(A_PEND, 4'b0001, 32'h3c);
        expect_val("level w1c no effect", 32'h1f);  rd(A_PEND, d); got.push_back(d);
        wr(A_CFG, 4'b0001, 32'h0000_003f);
        expect_val("mask wr latency", 32'h02);      got.push_back(32'(hw_int));
        step();
        expect_val("mask wr applied", 32'h1f);      got.push_back(32'(hw_int));
        wr(A_CFG, 4'b0010, 32'h0000_3f00);
        irq_src = 6'h00;
        step();
        expect_val("mode change keeps pend", 32'h1f); rd(A_PEND, d); got.push_back(d);
        wr(A_PEND, 4'b0001, 32'h3f);
        expect_val("cfg cleanup pend", 32'h0);      rd(A_PEND, d); got.push_back(d);
        foreach (got[i]) begin
            logic [31:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_total++;
            if (got[i] !== e) $display("FAIL %s: got %h required %h", nm, got[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_conflict();
        logic [31:0] got[$];
        logic [31:0] d;
        step();
        m_int_addr   = A_PEND;
        m_int_byteen = 4'b0001;
        m_int_wdata  = 32'h1;
        irq_src[0]   = 1'b1;
        #1;
        expect_val("read pre-write value", 32'h0);  got.push_back(m_int_rdata);
        step();
        m_int_byteen = '0;
        m_int_wdata  = '0;
        expect_val("set beats clear", 32'h1);       rd(A_PEND, d); got.push_back(d);
        irq_src[0] = 1'b0;
        wr(A_PEND, 4'b0001, 32'h1);
        expect_val("conflict cleanup", 32'h0);      rd(A_PEND, d); got.push_back(d);
        foreach (got[i]) begin
            logic [31:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_total++;
            if (got[i] !== e) $display("FAIL %s: got %h required %h", nm, got[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got[$];
        logic [31:0] d;
        wr(A_CFG, 4'b0011, 32'h0000_3f00);
        irq_src = 6'h3f;
        step();
        expect_val("pre-reset pend", 32'h3f);       rd(A_PEND, d); got.push_back(d);
        step();
        expect_val("pre-reset masked hw", 32'h0);   got.push_back(32'(hw_int));
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_val("post-reset cfg", 32'h0000_3f3f); rd(A_CFG, d); got.push_back(d);
        expect_val("post-reset pend", 32'h0);       rd(A_PEND, d); got.push_back(d);
        expect_val("post-reset hw", 32'h0);         got.push_back(32'(hw_int));
        step();
        expect_val("first cycle hw", 32'h0);        got.push_back(32'(hw_int));
        expect_val("first cycle pend", 32'h3f);     rd(A_PEND, d); got.push_back(d);
        step();
        expect_val("second cycle hw", 32'h3f);      got.push_back(32'(hw_int));
        expect_val("second cycle any", 32'h1);      got.push_back(32'(int_any));
        foreach (got[i]) begin
            logic [31:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_total++;
            if (got[i] !== e) $display("FAIL %s: got %h required %h", nm, got[i], e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ext_pulse();
        test_w1c_status();
        test_back_to_back();
        test_config_level();
        test_conflict();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
